capture_buffer: RTL and testbench
=================================

CAPTURE_BUFFER -- requirements
Module: capture_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 12, ADC sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, capture length in samples (power of two, 16..1024).
REQ-003 SHALL have parameter PRE_TRIG, default 64, samples kept before the trigger (0 < PRE_TRIG < DEPTH).
REQ-004 SHALL have port i_clk  input  1  system clock (25 MHz ADC-bridge clock).
REQ-005 SHALL have port i_RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_response_valid  input  1  ADC sample strobe.
REQ-007 SHALL have port i_sample_data  input  DATA_W  ADC sample.
REQ-008 SHALL have port i_trigger  input  1  trigger pulse from the trigger stage.
REQ-009 SHALL have port o_data  output  DATA_W  readout sample to the serial transmitter.
REQ-010 SHALL have port o_valid  output  1  o_data valid.
REQ-011 SHALL have port i_ready  input  1  transmitter accepts o_data.
REQ-012 SHALL have port o_last  output  1  marks final readout word, qualified by o_valid.
REQ-013 SHALL have port o_TRANSFER_DONE  output  1  one-cycle pulse after the last word is accepted.
REQ-014 SHALL have port o_armed  output  1  high while waiting for a trigger.

Function
REQ-015 SHALL implement states FILL, ARMED, POST, READOUT, DONE.
REQ-016 In FILL, each i_response_valid SHALL write i_sample_data at wr_ptr, increment wr_ptr (mod DEPTH) and a fill count; go to ARMED when count reaches PRE_TRIG.
REQ-017 In FILL, i_trigger SHALL be ignored.
REQ-018 In ARMED, samples SHALL keep writing circularly; i_trigger high SHALL record trig_ptr = wr_ptr and go to POST.
REQ-019 If i_trigger and i_response_valid coincide in ARMED, that sample SHALL be written and counted as the first post-trigger sample (trig_ptr = address of that sample).
REQ-020 In POST, writes SHALL continue until DEPTH-PRE_TRIG post-trigger samples are stored (including any coincident sample), then go to READOUT.
REQ-021 READOUT SHALL start at address (trig_ptr - PRE_TRIG) mod DEPTH and present DEPTH words in chronological order, wrapping at DEPTH.
REQ-022 A word SHALL transfer on i_clk when o_valid and i_ready are both high; o_data and o_last SHALL hold stable while o_valid is high and i_ready is low.
REQ-023 First o_valid SHALL assert no later than 2 cycles after entering READOUT; with i_ready held high, throughput SHALL be one word per cycle.
REQ-024 i_response_valid and i_trigger SHALL be ignored in READOUT and DONE; no memory write occurs.
REQ-025 o_last SHALL be high with the DEPTH-th word only.
REQ-026 On acceptance of the last word, go to DONE; DONE SHALL pulse o_TRANSFER_DONE for exactly one cycle and return to FILL with fill count cleared.
REQ-027 o_armed SHALL be high only in ARMED.
REQ-028 Pointer arithmetic SHALL be $clog2(DEPTH) bits, natural modulo wrap.

Reset
REQ-029 i_RESET SHALL take effect on the next i_clk edge from any state, including mid-READOUT.
REQ-030 Reset values: state FILL, pointers 0, count 0, o_valid 0, o_last 0, o_TRANSFER_DONE 0, o_armed 0, o_data 0.
REQ-031 Memory contents SHALL NOT be reset; a readout aborted by reset SHALL NOT produce o_TRANSFER_DONE.

Configuration
REQ-032 Macro CAPTURE_HEADER_EN SHALL, when defined, emit one header word {DATA_W{1'b1}} before the sample words (DEPTH+1 words total; o_last still on final sample).
REQ-033 Without CAPTURE_HEADER_EN, exactly DEPTH sample words SHALL be emitted and no header logic SHALL exist.

Structure
REQ-034 State enum encoding and the header word constant SHALL live in shared package scope_pkg.
REQ-035 Sample storage SHALL be sub-module capture_ram (simple dual-port, 1-cycle registered read, M9K-inferable); control and handshake stay in capture_buffer.

Verification
REQ-036 DEPTH=16, PRE_TRIG=4, ramp samples 0,1,2..., trigger on sample 10 -> readout 6..21, o_last with 21, one o_TRANSFER_DONE pulse.
REQ-037 Trigger asserted during FILL (sample 2) -> ignored; o_armed rises after sample 3; later trigger on sample 30 -> readout 26..41.
REQ-038 Buffer wraps several times before trigger (trigger on sample 100) -> readout 96..111 in order across the wrap boundary.
REQ-039 i_ready toggled pseudo-randomly during readout -> no lost, duplicated or changed words; o_data stable while stalled.
REQ-040 i_RESET asserted at readout word 7 -> o_valid low next cycle, no o_TRANSFER_DONE, fresh capture then succeeds.
REQ-041 With CAPTURE_HEADER_EN, DATA_W=12, same stimulus as REQ-036 -> first word 0xFFF, then 6..21, 17 words total.

Source files
------------

// File: rtl/capture_buffer_pkg.sv
// Shared definitions for the scope capture path: FSM state encoding and the readout header word.
package scope_pkg;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_POST    = 3'd2,
        ST_READOUT = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_e;

    // All-ones marker; users slice the low DATA_W bits.
    localparam logic [63:0] HEADER_WORD = {64{1'b1}};

endpackage

// File: rtl/capture_buffer_if.sv
// Readout stream from the capture buffer to the serial transmitter (valid/ready, last marker).
interface capture_buffer_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_last;
    logic              i_ready;

    modport master (output o_data, output o_valid, output o_last, input i_ready);
    modport slave  (input o_data, input o_valid, input o_last, output i_ready);
endinterface

// File: rtl/capture_buffer_ram.sv
// Simple dual-port sample store with a registered read port; contents are never reset.
module capture_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_p1;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_p1 <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_p1;
endmodule

// File: rtl/capture_buffer.sv
// Pre/post-trigger sample capture with chronological valid/ready readout.
// Optional macro CAPTURE_HEADER_EN prepends one all-ones header word to each readout.
module capture_buffer
    import scope_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic              i_clk,
    input  logic              i_RESET,
    input  logic              i_response_valid,
    input  logic [DATA_W-1:0] i_sample_data,
    input  logic              i_trigger,
    capture_buffer_if.master  rd_if,
    output logic              o_TRANSFER_DONE,
    output logic              o_armed
);
    localparam int AW = $clog2(DEPTH);
`ifdef CAPTURE_HEADER_EN
    localparam int TOTAL = DEPTH + 1;
`else
    localparam int TOTAL = DEPTH;
`endif
    localparam logic [AW-1:0] PRE_AW     = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST   = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST  = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW:0]   TOTAL_W    = (AW+1)'(TOTAL);
    localparam logic [AW:0]   TOTAL_LAST = (AW+1)'(TOTAL - 1);

    cap_state_e        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW:0]       rd_cnt_q, rd_cnt_d;
    logic              o_valid_q, o_valid_d;
    logic              o_last_q, o_last_d;
    logic              wr_en, rd_en, advance;
    logic [DATA_W-1:0] ram_data;
`ifdef CAPTURE_HEADER_EN
    logic              hdr_sel_q, hdr_sel_d;
`endif

    capture_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk_i     (i_clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (i_sample_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q   <= ST_FILL;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
`ifdef CAPTURE_HEADER_EN
            hdr_sel_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
`ifdef CAPTURE_HEADER_EN
            hdr_sel_q <= hdr_sel_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        advance   = 1'b0;
`ifdef CAPTURE_HEADER_EN
        hdr_sel_d = hdr_sel_q;
`endif
        case (state_q)
            ST_FILL: begin
                if (i_response_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == PRE_LAST) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (i_response_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                // A coincident sample is the first post-trigger sample, so the window starts at wr_ptr.
                if (i_trigger) begin
                    rd_ptr_d = wr_ptr_q - PRE_AW;
                    rd_cnt_d = '0;
                    cnt_d    = i_response_valid ? AW'(1) : '0;
                    state_d  = (i_response_valid && POST_LAST == '0) ? ST_READOUT : ST_POST;
                end
            end
            ST_POST: begin
                if (i_response_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == POST_LAST) state_d = ST_READOUT;
                end
            end
            ST_READOUT: begin
                // Output register and RAM read register advance together, so a stall freezes both.
                advance = !o_valid_q || rd_if.i_ready;
                if (advance) begin
                    rd_en     = (rd_cnt_q != TOTAL_W);
                    o_valid_d = rd_en;
                    o_last_d  = rd_en && (rd_cnt_q == TOTAL_LAST);
                    if (rd_en) begin
                        rd_cnt_d = rd_cnt_q + (AW+1)'(1);
`ifdef CAPTURE_HEADER_EN
                        hdr_sel_d = (rd_cnt_q == '0);
                        if (rd_cnt_q != '0) rd_ptr_d = rd_ptr_q + AW'(1);
`else
                        rd_ptr_d = rd_ptr_q + AW'(1);
`endif
                    end
                end
                if (o_valid_q && o_last_q && rd_if.i_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
            default: state_d = ST_FILL;
        endcase
    end

`ifdef CAPTURE_HEADER_EN
    assign rd_if.o_data = !o_valid_q ? '0 : (hdr_sel_q ? HEADER_WORD[DATA_W-1:0] : ram_data);
`else
    assign rd_if.o_data = o_valid_q ? ram_data : '0;
`endif
    assign rd_if.o_valid   = o_valid_q;
    assign rd_if.o_last    = o_last_q;
    assign o_TRANSFER_DONE = (state_q == ST_DONE);
    assign o_armed         = (state_q == ST_ARMED);
endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer (DEPTH=16, PRE_TRIG=4, DATA_W=12).
module tb_capture_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv  = 1'b0;
    logic [11:0] sd  = '0;
    logic        trg = 1'b0;
    logic        done, armed;
    int          n_assert = 0;
    int          n_fail   = 0;

`ifdef CAPTURE_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    capture_buffer_if #(.DATA_W(12)) rd_bus ();

    capture_buffer #(.DATA_W(12), .DEPTH(16), .PRE_TRIG(4)) dut (
        .i_clk            (clk),
        .i_RESET          (rst),
        .i_response_valid (rv),
        .i_sample_data    (sd),
        .i_trigger        (trg),
        .rd_if            (rd_bus),
        .o_TRANSFER_DONE  (done),
        .o_armed          (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int first, input int k);
        if (HDR != 0 && k == 0) return 32'hFFF;
        return 32'(first + k - HDR);
    endfunction

    // One sample per cycle with values v0..v1; trigger coincides with value trig_v.
    task automatic feed(input int v0, input int v1, input int trig_v);
        for (int v = v0; v <= v1; v++) begin
            @(negedge clk);
            rv  = 1'b1;
            sd  = 12'(v);
            trg = (v == trig_v);
        end
        @(negedge clk);
        rv  = 1'b0;
        trg = 1'b0;
    endtask

    task automatic read_words(input string tag, input int first, input bit rnd);
        int   total = 16 + HDR;
        int   k = 0;
        int   cyc = 0;
        int   guard = 0;
        logic r;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [11:0] pd = '0;
        rd_bus.i_ready = 1'b0;
        while (!rd_bus.o_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_valid_rise"}, 32'(rd_bus.o_valid), 32'd1);
        while (k < total && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pv && !pr) begin
                check({tag, "_stall_valid"}, 32'(rd_bus.o_valid), 32'd1);
                check({tag, "_stall_data"}, 32'(rd_bus.o_data), 32'(pd));
                check({tag, "_stall_last"}, 32'(rd_bus.o_last), 32'(pl));
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_bus.i_ready = r;
            if (rd_bus.o_valid && r) begin
                check({tag, "_word"}, 32'(rd_bus.o_data), exp_word(first, k));
                check({tag, "_last"}, 32'(rd_bus.o_last), 32'(k == total - 1));
                k++;
            end
            pv = rd_bus.o_valid;
            pr = r;
            pd = rd_bus.o_data;
            pl = rd_bus.o_last;
        end
        check({tag, "_count"}, 32'(k), 32'(total));
        if (!rnd) check({tag, "_throughput"}, 32'(cyc), 32'(total));
        @(negedge clk);
        rd_bus.i_ready = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_valid_after"}, 32'(rd_bus.o_valid), 32'd0);
        @(negedge clk);
        check({tag, "_done_clear"}, 32'(done), 32'd0);
        check({tag, "_armed_fill"}, 32'(armed), 32'd0);
    endtask

    initial begin
        rd_bus.i_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(rd_bus.o_valid), 32'd0);
        check("rst_last", 32'(rd_bus.o_last), 32'd0);
        check("rst_data", 32'(rd_bus.o_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        rst = 1'b0;

        // Ramp with trigger on sample 10, then stray samples/trigger while readout is stalled.
        feed(0, 21, 10);
        check("a_armed_readout", 32'(armed), 32'd0);
        feed(200, 202, 201);
        read_words("a", 6, 1'b0);

        // Trigger during fill is ignored; armed rises after the fourth sample.
        feed(0, 2, 2);
        check("b_armed_after2", 32'(armed), 32'd0);
        feed(3, 3, -1);
        check("b_armed_after3", 32'(armed), 32'd1);
        feed(4, 29, -1);
        check("b_armed_before_trig", 32'(armed), 32'd1);
        feed(30, 41, 30);
        check("b_armed_after_trig", 32'(armed), 32'd0);
        read_words("b", 26, 1'b0);

        // Several wraps before the trigger, read back with a randomly stalling receiver.
        feed(0, 111, 100);
        read_words("c", 96, 1'b1);

        // Reset in the middle of readout, then a fresh capture.
        feed(0, 21, 10);
        rd_bus.i_ready = 1'b0;
        for (int g = 0; g < 10 && !rd_bus.o_valid; g++) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            rd_bus.i_ready = 1'b1;
            check("d_valid", 32'(rd_bus.o_valid), 32'd1);
            check("d_word", 32'(rd_bus.o_data), exp_word(6, k));
        end
        @(negedge clk);
        rd_bus.i_ready = 1'b0;
        check("d_word7_valid", 32'(rd_bus.o_valid), 32'd1);
        check("d_word7_data", 32'(rd_bus.o_data), exp_word(6, 7));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("d_rst_valid", 32'(rd_bus.o_valid), 32'd0);
        check("d_rst_last", 32'(rd_bus.o_last), 32'd0);
        check("d_rst_data", 32'(rd_bus.o_data), 32'd0);
        check("d_rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("d_no_done", 32'(done), 32'd0);
        end
        feed(500, 521, 510);
        read_words("d_fresh", 506, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
